// File: rtl/alu_logical_ctrl.sv
// Sequencer for an external 32-bit logical unit: accepts one request at a time,
// drives the unit's operands/selects, captures the result and holds it until consumed.
module alu_logical_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic             alu_sel0,
  output logic             alu_sel1,
  input  logic [31:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state, state_nxt;
  logic        accept;
  logic        op_legal;
  logic        rsp_fire;
  logic        op_nor;
  logic [31:0] exec_data;
  logic        sel0_nxt;
  logic        sel1_nxt;

  // req_ready is gated by rst_n so it reads 0 while reset is held
  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    op_legal  = ~req_op[2];
    exec_data = op_nor ? ~alu_out : alu_out;
    // NOR reuses the OR select; the inversion is applied on capture
    sel1_nxt  = (req_op[1:0] == 2'b10);
    sel0_nxt  = req_op[0];
    unique case (state)
      IDLE: begin
        accept = req_valid;
        if (req_valid) begin
          state_nxt = op_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_fire = rsp_ready;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_sel0 <= 1'b0;
      alu_sel1 <= 1'b0;
      op_nor   <= 1'b0;
    end else if (accept && op_legal) begin
      alu_in1  <= req_a;
      alu_in2  <= req_b;
      alu_sel0 <= sel0_nxt;
      alu_sel1 <= sel1_nxt;
      op_nor   <= (req_op[1:0] == 2'b11);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      rsp_zero <= 1'b0;
    end else if (accept && !op_legal) begin
      rsp_data <= '0;
      rsp_err  <= 1'b1;
      rsp_zero <= 1'b1;
    end else if (state == EXEC) begin
      rsp_data <= exec_data;
      rsp_err  <= 1'b0;
      rsp_zero <= (exec_data == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_fire) begin
      op_count <= op_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_logical_ctrl.sv
// Randomized self-checking bench for alu_logical_ctrl with an external logical-unit model.
module tb_alu_logical_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [31:0]      alu_in1;
  logic [31:0]      alu_in2;
  logic             alu_sel0;
  logic             alu_sel1;
  logic [31:0]      alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             rsp_zero;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  int          m_count;
  logic [31:0] m_in1;
  logic [31:0] m_in2;
  int          m_sel;

  always #5 clk = ~clk;

  alu_logical_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel0(alu_sel0), .alu_sel1(alu_sel1),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_zero(rsp_zero), .op_count(op_count)
  );

  // External logical unit
  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    case ({alu_sel1, alu_sel0})
      2'b00: alu_out = alu_in1 & alu_in2;
      2'b01: alu_out = alu_in1 | alu_in2;
      2'b10: alu_out = alu_in1 ^ alu_in2;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_sel(input logic [2:0] op);
    case (op)
      3'd0:    return 0;
      3'd1:    return 1;
      3'd2:    return 2;
      default: return 1;
    endcase
  endfunction

  task automatic check_alu(input string tag);
    check({tag, "_in1"}, alu_in1, m_in1);
    check({tag, "_in2"}, alu_in2, m_in2);
    check({tag, "_sel"}, {30'd0, alu_sel1, alu_sel0}, m_sel);
  endtask

  // Called at a negedge with the block idle; returns at a negedge, idle again.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] exp_data;
    logic        legal;
    legal    = !op[2];
    exp_data = ref_result(op, a, b);
    check("idle_ready", req_ready, 1);
    check("idle_valid", rsp_valid, 0);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    // scramble request inputs while busy; they must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 3'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    check("busy_ready", req_ready, 0);
    if (legal) begin
      rsp_ready = 1'($urandom_range(0, 1));
      m_in1 = a;
      m_in2 = b;
      m_sel = ref_sel(op);
      check("exec_valid", rsp_valid, 0);
      check_alu("exec");
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("resp_valid", rsp_valid, 1);
    check("resp_data", rsp_data, exp_data);
    check("resp_err", rsp_err, legal ? 0 : 1);
    check("resp_zero", rsp_zero, (exp_data == 0) ? 1 : 0);
    check("resp_count", op_count, m_count);
    check_alu("resp");
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, exp_data);
      check("hold_err", rsp_err, legal ? 0 : 1);
      check("hold_ready", req_ready, 0);
      check("hold_count", op_count, m_count);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    m_count = (m_count + 1) % (1 << CNT_W);
    check("done_valid", rsp_valid, 0);
    check("done_count", op_count, m_count);
    check("done_ready", req_ready, 1);
    check_alu("done");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_valid"}, rsp_valid, 0);
    check({tag, "_data"}, rsp_data, 0);
    check({tag, "_err"}, rsp_err, 0);
    check({tag, "_zero"}, rsp_zero, 0);
    check({tag, "_count"}, op_count, 0);
    check({tag, "_in1"}, alu_in1, 0);
    check({tag, "_in2"}, alu_in2, 0);
    check({tag, "_sel"}, {30'd0, alu_sel1, alu_sel0}, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    m_count   = 0;
    m_in1     = '0;
    m_in2     = '0;
    m_sel     = 0;
    #1;
    check_reset_values("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // response-ready while idle must not count
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_rspready_count", op_count, m_count);
      check("idle_rspready_valid", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    do_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op(3'b011, 32'h0000_FFFF, 32'hFFFF_0000, 0);
    do_op(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op(3'b010, 32'hAAAA_AAAA, 32'h5555_5555, 5);
    check("wrap_count", op_count, 0);

    // reset while the operation is in EXEC
    req_valid = 1'b1;
    req_op    = 3'b001;
    req_a     = 32'h0F0F_0000;
    req_b     = 32'h0000_0F0F;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_reset_values("midexec");
    @(negedge clk);
    rst_n   = 1'b1;
    m_count = 0;
    m_in1   = '0;
    m_in2   = '0;
    m_sel   = 0;
    @(posedge clk);
    @(negedge clk);
    check("postrst_valid", rsp_valid, 0);
    check("postrst_count", op_count, 0);
    do_op(3'b001, 32'h0F0F_0000, 32'h0000_0F0F, 1);

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      do_op(op, a, b, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
